edge_detector_bank: RTL and testbench
=====================================

# edge_detector_bank

Multi-channel, parametrised edge detector for asynchronous inputs such as buttons, switches and external strobes. Each channel synchronises its input, debounces it, and detects rising and/or falling transitions under a per-channel mode select. Each detected edge produces a one-cycle pulse and sets a sticky pending flag, which software or downstream logic clears. The block sits between board-level inputs and the control FSMs or interrupt logic.

## Interface
- WIDTH, default 4: number of independent channels (≥1).
- SYNC_STAGES, default 2: synchroniser flip-flops per channel (≥2).
- DEBOUNCE, default 3: consecutive cycles the synchronised input must differ from the stable level before the level is accepted (≥1; 1 = no filtering).
- clk  input  1  system clock; all state updates on posedge.
- async_nreset  input  1  asynchronous, active-low reset.
- in  input  WIDTH  raw asynchronous inputs.
- rise_en  input  WIDTH  per-channel rising-edge detect enable.
- fall_en  input  WIDTH  per-channel falling-edge detect enable.
- clear  input  WIDTH  per-channel synchronous pending clear.
- level  output  WIDTH  debounced stable level.
- pulse  output  WIDTH  one-cycle registered edge strobe.
- pending  output  WIDTH  sticky edge flags.
- irq  output  1  OR of pending (combinational from registers).

## Operation
Each channel behaves identically and independently. Channels share only clk, async_nreset and the irq reduction.
- Reset (async_nreset=0, asynchronous): all synchroniser stages, debounce counters, level, pulse and pending clear to 0. irq=0.
- Synchroniser: in[i] shifts through SYNC_STAGES flops; the last stage is sync[i].
- Debounce counter: width is clog2(DEBOUNCE), minimum 1 bit. Evaluated at each edge:
  - sync == level: the counter clears to 0.
  - sync != level and cnt < DEBOUNCE-1: the counter increments.
  - sync != level and cnt == DEBOUNCE-1: level <= sync and the counter clears to 0. This is an "accept" event.
- The counter never exceeds DEBOUNCE-1, so there is no wrap-around.
- Edge qualification happens at the accept edge, using rise_en/fall_en as sampled at that edge.
  - A rise is an accept with the new level=1; it is qualified if rise_en[i]=1.
  - A fall is an accept with the new level=0; it is qualified if fall_en[i]=1.
  - With both enables set, both edge directions are reported; with neither set, edges are tracked in level only.
- pulse[i] <= qualified event. It is high for exactly one cycle per event, and no two events can occur on consecutive edges when DEBOUNCE≥1 and SYNC_STAGES≥2 except for DEBOUNCE=1 toggling inputs, where back-to-back pulses are allowed.
- pending[i] <= qualified event | (pending[i] & ~clear[i]).
  - Set has priority: simultaneous clear and event leaves pending=1.
  - Clear while pending=0 is a no-op.
- Enable changes never alter an existing pending flag or the level/counter path.
- Reset level is 0, so an input held high through reset release produces a rise event (if rise_en=1) after the normal latency.

## Timing
- Let edge k be the first posedge sampling the new input value into stage 0, with the input held stable afterwards.
- level, pulse and pending update at edge k+SYNC_STAGES+DEBOUNCE-1 and are visible in the following cycle. irq follows pending in the same cycle.
- Defaults (2, 3): the update is at edge k+4.
- Glitch rejection: an input that differs from level for fewer than DEBOUNCE consecutive synchronised samples produces no level change, pulse or pending.
- Defaults: high for 2 cycles is rejected; high for 3 cycles is accepted.
- Reset asserted mid-debounce: the counter clears immediately, the in-progress event is lost, and no pulse is emitted after release unless the input again differs from 0 for the full latency.

## Test plan
1. Reset with in=0000, rise_en=1111, fall_en=0000, then raise in[0] before edge k → level[0]=1, pulse[0]=1 for exactly the cycle after edge k+4, pending[0]=1, irq=1, other channels 0.
2. Glitch on in[1] high for 2 cycles, then 3 cycles (rise_en[1]=1) → no pulse for the 2-cycle glitch; one pulse, level[1]=1 for the 3-cycle input.
3. Channel 2 with rise_en=1, fall_en=1: in[2] 0→1, held 10 cycles, then 1→0 → two pulses 10 edges apart, level[2] tracks. Repeat with fall_en only → single pulse on the falling edge.
4. Assert clear[0] on the same edge as a new qualified event on ch0 → pending[0] stays 1. Assert clear[0] alone the next cycle → pending[0]=0, irq=0 if no other pending.
5. Hold in=1111 through reset release with rise_en=1111 → all four pulse simultaneously at release edge+4, pending=1111.
6. Assert async_nreset=0 mid-debounce (counter=2) on ch3 → outputs 0 immediately, no pulse after release with in[3]=0.

Source files
------------

// File: rtl/edge_detector_bank.sv
// edge_detector_bank: per-channel synchroniser, debounce filter and
// edge detector with one-cycle pulses, sticky pending flags and irq.
module edge_detector_bank #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] pending,
    output logic             irq
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic                   lvl_q;
        logic                   pulse_q;
        logic                   pend_q;
        logic                   sync;
        logic                   differ;
        logic                   accept;
        logic                   qual;

        assign sync   = sync_q[SYNC_STAGES-1];
        assign differ = sync ^ lvl_q;
        assign accept = differ && (cnt_q == CNT_MAX);
        assign qual   = accept && (sync ? rise_en[i] : fall_en[i]);

        // metastability synchroniser chain for the raw input
        always_ff @(posedge clk or negedge async_nreset) begin
            if (!async_nreset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
            end
        end

        // count consecutive differing samples, accept level when full
        always_ff @(posedge clk or negedge async_nreset) begin
            if (!async_nreset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                if (!differ || accept) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                if (accept) begin
                    lvl_q <= sync;
                end
            end
        end

        // edge strobe and sticky flag; a new event beats a clear
        always_ff @(posedge clk or negedge async_nreset) begin
            if (!async_nreset) begin
                pulse_q <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                pulse_q <= qual;
                pend_q  <= qual | (pend_q & ~clear[i]);
            end
        end

        assign level[i]   = lvl_q;
        assign pulse[i]   = pulse_q;
        assign pending[i] = pend_q;
    end

    assign irq = |pending;

endmodule

// File: tb/tb_edge_detector_bank.sv
// tb_edge_detector_bank: vector table, directed corner sequences and
// randomized stimulus against a sample-window reference model.
module tb_edge_detector_bank;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         async_nreset;
    logic [W-1:0] in;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] clear;
    logic [W-1:0] level;
    logic [W-1:0] pulse;
    logic [W-1:0] pending;
    logic         irq;

    int errors = 0;
    int checks = 0;

    edge_detector_bank #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE(D)
    ) dut (
        .clk(clk),
        .async_nreset(async_nreset),
        .in(in),
        .rise_en(rise_en),
        .fall_en(fall_en),
        .clear(clear),
        .level(level),
        .pulse(pulse),
        .pending(pending),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: the synchroniser is a pure delay of S samples,
    // and a level is accepted once the last D synchronised samples all
    // differ from the current level.
    bit           sq [W][$];
    bit           wq [W][$];
    logic [W-1:0] m_lvl;
    logic [W-1:0] m_pul;
    logic [W-1:0] m_pnd;

    typedef struct {
        logic [W-1:0] vin;
        logic [W-1:0] vclr;
        logic [W-1:0] lvl;
        logic [W-1:0] pul;
        logic [W-1:0] pnd;
        logic         irq;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            sq[i].delete();
            wq[i].delete();
            for (int j = 0; j < S; j++) sq[i].push_back(1'b0);
        end
        m_lvl = '0;
        m_pul = '0;
        m_pnd = '0;
    endtask

    task automatic model_edge();
        logic [W-1:0] nl, np, nd;
        bit s, acc;
        for (int i = 0; i < W; i++) begin
            s = sq[i].pop_front();
            sq[i].push_back(in[i]);
            wq[i].push_back(s);
            if (wq[i].size() > D) void'(wq[i].pop_front());
            acc = (wq[i].size() == D);
            for (int j = 0; j < wq[i].size(); j++)
                if (wq[i][j] == m_lvl[i]) acc = 1'b0;
            nl[i] = acc ? s : m_lvl[i];
            np[i] = acc && (s ? rise_en[i] : fall_en[i]);
            nd[i] = np[i] | (m_pnd[i] & ~clear[i]);
        end
        m_lvl = nl;
        m_pul = np;
        m_pnd = nd;
    endtask

    task automatic step(input logic [W-1:0] vin,
                        input logic [W-1:0] vclr);
        in    = vin;
        clear = vclr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"},   32'(level),   32'(m_lvl));
        chk({tag, ".pulse"},   32'(pulse),   32'(m_pul));
        chk({tag, ".pending"}, 32'(pending), 32'(m_pnd));
        chk({tag, ".irq"},     32'(irq),     32'(|m_pnd));
    endtask

    task automatic do_reset(input logic [W-1:0] vin);
        in    = vin;
        clear = '0;
        async_nreset = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        async_nreset = 1'b1;
    endtask

    initial begin
        int pc;
        int pj[$];
        logic [W-1:0] rin;
        int hold[W];

        // vectors: ch0 rise, clear, then a disabled fall
        tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[4]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 1'b1};
        tbl[5]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1};
        tbl[6]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[7]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[8]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[9]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[10] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

        async_nreset = 1'b0;
        in      = '0;
        rise_en = 4'hF;
        fall_en = 4'h0;
        clear   = '0;
        repeat (3) @(negedge clk);
        chk("rst.level",   32'(level),   32'h0);
        chk("rst.pulse",   32'(pulse),   32'h0);
        chk("rst.pending", 32'(pending), 32'h0);
        chk("rst.irq",     32'(irq),     32'h0);
        model_reset();
        async_nreset = 1'b1;

        for (int j = 0; j < 12; j++) begin
            step(tbl[j].vin, tbl[j].vclr);
            chk($sformatf("tbl%0d.level", j),
                32'(level), 32'(tbl[j].lvl));
            chk($sformatf("tbl%0d.pulse", j),
                32'(pulse), 32'(tbl[j].pul));
            chk($sformatf("tbl%0d.pending", j),
                32'(pending), 32'(tbl[j].pnd));
            chk($sformatf("tbl%0d.irq", j),
                32'(irq), 32'(tbl[j].irq));
        end

        // glitch on ch1: 2 cycles rejected, 3 cycles accepted
        fall_en = 4'h0;
        pc = 0;
        for (int j = 0; j < 8; j++) begin
            step((j < 2) ? 4'h2 : 4'h0, 4'h0);
            check_all("glitch2");
            if (pulse[1]) pc++;
        end
        chk("glitch2.count", 32'(pc), 32'd0);
        pc = 0;
        for (int j = 0; j < 8; j++) begin
            step((j < 3) ? 4'h2 : 4'h0, 4'h0);
            check_all("glitch3");
            if (pulse[1]) begin
                pc++;
                chk("glitch3.when", 32'(j), 32'd4);
                chk("glitch3.level", 32'(level[1]), 32'd1);
            end
        end
        chk("glitch3.count", 32'(pc), 32'd1);

        // ch2 with both enables, then fall only
        do_reset(4'h0);
        rise_en = 4'h4;
        fall_en = 4'h4;
        pj.delete();
        for (int j = 0; j < 20; j++) begin
            step((j < 10) ? 4'h4 : 4'h0, 4'h0);
            check_all("both");
            if (pulse[2]) pj.push_back(j);
        end
        chk("both.count", 32'(pj.size()), 32'd2);
        if (pj.size() == 2)
            chk("both.spacing", 32'(pj[1] - pj[0]), 32'd10);
        rise_en = 4'h0;
        pj.delete();
        for (int j = 0; j < 20; j++) begin
            step((j < 10) ? 4'h4 : 4'h0, 4'h0);
            check_all("fallonly");
            if (pulse[2]) pj.push_back(j);
        end
        chk("fallonly.count", 32'(pj.size()), 32'd1);
        if (pj.size() == 1)
            chk("fallonly.when", 32'(pj[0]), 32'd14);

        // clear coinciding with a new event on ch0
        do_reset(4'h0);
        rise_en = 4'hF;
        fall_en = 4'hF;
        for (int j = 0; j < 9; j++) begin
            step((j < 5) ? 4'h1 : 4'h0, 4'h0);
            check_all("clr.pre");
        end
        step(4'h0, 4'h1);
        check_all("clr.same");
        chk("clr.same.pulse", 32'(pulse[0]), 32'd1);
        chk("clr.same.pending", 32'(pending[0]), 32'd1);
        step(4'h0, 4'h1);
        check_all("clr.alone");
        chk("clr.alone.pending", 32'(pending[0]), 32'd0);
        chk("clr.alone.irq", 32'(irq), 32'd0);

        // inputs high through reset release
        rise_en = 4'hF;
        do_reset(4'hF);
        for (int j = 0; j < 6; j++) begin
            step(4'hF, 4'h0);
            check_all("hold");
            if (j == 3) chk("hold.early", 32'(pulse), 32'h0);
            if (j == 4) begin
                chk("hold.pulse", 32'(pulse), 32'hF);
                chk("hold.pending", 32'(pending), 32'hF);
            end
        end

        // reset during an in-progress fall on ch3
        fall_en = 4'hF;
        for (int j = 0; j < 4; j++) begin
            step(4'h7, 4'h0);
            check_all("midrst.pre");
        end
        async_nreset = 1'b0;
        #1;
        chk("midrst.level", 32'(level), 32'h0);
        chk("midrst.pending", 32'(pending), 32'h0);
        chk("midrst.irq", 32'(irq), 32'h0);
        in = 4'h0;
        @(negedge clk);
        model_reset();
        async_nreset = 1'b1;
        pc = 0;
        for (int j = 0; j < 10; j++) begin
            step(4'h0, 4'h0);
            check_all("midrst.post");
            if (pulse != 0) pc++;
        end
        chk("midrst.nopulse", 32'(pc), 32'd0);

        // randomized stimulus against the model
        do_reset(4'h0);
        rin = '0;
        for (int i = 0; i < W; i++) hold[i] = 0;
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < W; i++) begin
                if (hold[i] == 0) begin
                    rin[i]  = ~rin[i];
                    hold[i] = $urandom_range(1, 6);
                end
                hold[i]--;
            end
            rise_en = 4'($urandom);
            fall_en = 4'($urandom);
            step(rin, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
